vga_mem_arbiter: RTL and testbench
==================================

Name: vga_mem_arbiter

Overview:
- Shares the single synchronous-read memory port between two requesters: the display glyph/digit fetcher and the CPU load/store unit.
- Sits between both requesters and the block RAM holding digit values and glyph sprites.
- During active video (bright=1) the display has priority; a starvation counter guarantees the CPU a slot.
- Outside active video the CPU has priority.

Parameters:
- ADDR_W, 16, address width of the memory port.
- DATA_W, 16, data width of the memory port.
- RD_LAT, 1, memory read latency in cycles (1..4).
- CPU_MAX_WAIT, 4, maximum consecutive cycles the CPU is denied while bright=1 before it is forced a grant (1..15).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- bright  in  1  active-video window flag from the VGA timing block.
- disp_req  in  1  display fetch request (read only).
- disp_addr  in  ADDR_W  display fetch address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rdata  out  DATA_W  read data returned to the display.
- disp_valid  out  1  disp_rdata valid this cycle.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write enable (1=write, 0=read).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rdata  out  DATA_W  read data returned to the CPU.
- cpu_valid  out  1  cpu_rdata valid this cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after the address.

Behaviour:
- Reset (reset=0, async): all grants, valids and mem_we are 0; wait counter is 0; return pipeline is cleared; rdata outputs are 0. Any requests in flight are dropped with no valid pulse.
- Arbitration is combinational within the cycle. A requester must hold req and its address/data stable until it sees gnt.
- At most one gnt per cycle. Grant rules, in priority order:
  1. Only one requester active: that requester is granted.
  2. Both active, bright=1, wait counter == CPU_MAX_WAIT: CPU is granted.
  3. Both active, bright=1, otherwise: display is granted.
  4. Both active, bright=0: CPU is granted.
- The granted requester's addr drives mem_addr. mem_we = cpu_gnt & cpu_we. mem_wdata = cpu_wdata.
- With no grant: mem_we=0 and mem_addr holds its previous value.
- Wait counter (4 bits):
  - Increments when cpu_req=1, cpu_gnt=0 and bright=1.
  - Clears on cpu_gnt, on cpu_req=0, or when bright=0.
  - Saturates at CPU_MAX_WAIT.
- Return pipeline: RD_LAT-deep shift register of tags {valid, owner}. A read grant pushes valid=1; writes and idle cycles push valid=0.
- At the pipeline output, mem_rdata is registered into the owner's rdata and that owner's valid pulses for 1 cycle. Total read latency from gnt to valid is RD_LAT+1 cycles.
- The non-owner's rdata holds its last value.
- Back-to-back reads are accepted every cycle; full throughput, no bubbles.
- bright changes mid-stream: the new priority applies in the same cycle. In-flight reads still return to their original owner.
- Writes never produce cpu_valid.
- CPU read-after-write to the same address in consecutive cycles returns the new data (memory is write-first).

Optional Feature:
- Macro: VGA_MEM_ARB_STATS_EN.
- Defined: adds output port disp_stall_cnt, 16 bits. It increments each cycle disp_req=1 and disp_gnt=0, saturates at 16'hFFFF, and clears on reset or on the rising edge of bright (start of each active line).
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 while driving requests -> all gnt/valid/mem_we=0. Release -> first disp_req at addr 16'h0040 gets gnt the same cycle and disp_valid 2 cycles later (RD_LAT=1) with the memory word.
- Display priority: bright=1, both requesting continuously, CPU_MAX_WAIT=4 -> grant sequence D,D,D,D,C,D,D,D,D,C; counter returns to 0 after each C.
- Blanking priority: bright=0, both requesting -> CPU granted every cycle and display starves. bright rises -> display granted that cycle.
- Write/read: CPU writes 16'hBEEF to 16'h0100, then reads 16'h0100 -> mem_we=1 for one cycle only, no cpu_valid for the write, cpu_rdata=16'hBEEF with cpu_valid at gnt+2.
- Interleaved reads: alternate D(16'h0010), C(16'h0020), D(16'h0011) grants -> valids return in order to correct owners; disp_rdata never shows CPU data.
- Mid-flight reset: assert reset the cycle after a read gnt -> no valid pulse afterwards; pipeline empty after release.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one sync-read memory port between display fetch and CPU.
// Optional stall counter output enabled by `define VGA_MEM_ARB_STATS_EN.
module vga_mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int RD_LAT       = 1,
   parameter int CPU_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bright,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_MEM_ARB_STATS_EN
   ,
   output logic [15:0]       disp_stall_cnt
`endif
);

   localparam logic [3:0] LP_MAX_WAIT = 4'(CPU_MAX_WAIT);

   logic              w_cpu_gnt;
   logic              w_disp_gnt;
   logic              w_rd_gnt;
   logic [3:0]        r_wait;
   logic [ADDR_W-1:0] r_addr;
   logic [RD_LAT-1:0] r_tag_v;
   logic [RD_LAT-1:0] r_tag_o;

   // Grants are forced low while reset is held so nothing reaches memory.
   always_comb begin
      w_cpu_gnt  = reset & cpu_req &
                   (~disp_req | ~bright | (r_wait == LP_MAX_WAIT));
      w_disp_gnt = reset & disp_req & ~w_cpu_gnt;
      w_rd_gnt   = w_disp_gnt | (w_cpu_gnt & ~cpu_we);
   end

   assign cpu_gnt   = w_cpu_gnt;
   assign disp_gnt  = w_disp_gnt;
   assign mem_we    = w_cpu_gnt & cpu_we;
   assign mem_wdata = cpu_wdata;

   always_comb begin
      mem_addr = r_addr;
      if (w_cpu_gnt)
         mem_addr = cpu_addr;
      else if (w_disp_gnt)
         mem_addr = disp_addr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_addr <= '0;
      else if (w_cpu_gnt | w_disp_gnt)
         r_addr <= mem_addr;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_wait <= '0;
      else if (w_cpu_gnt | ~cpu_req | ~bright)
         r_wait <= '0;
      else if (r_wait < LP_MAX_WAIT)
         r_wait <= r_wait + 4'd1;
   end

   // Tag pipeline tracks {valid, owner}; owner 1 = CPU, 0 = display.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tag_v <= '0;
         r_tag_o <= '0;
      end else begin
         r_tag_v[0] <= w_rd_gnt;
         r_tag_o[0] <= w_cpu_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_o[i] <= r_tag_o[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_valid <= 1'b0;
         cpu_valid  <= 1'b0;
         disp_rdata <= '0;
         cpu_rdata  <= '0;
      end else begin
         disp_valid <= r_tag_v[RD_LAT-1] & ~r_tag_o[RD_LAT-1];
         cpu_valid  <= r_tag_v[RD_LAT-1] &  r_tag_o[RD_LAT-1];
         if (r_tag_v[RD_LAT-1] & ~r_tag_o[RD_LAT-1])
            disp_rdata <= mem_rdata;
         if (r_tag_v[RD_LAT-1] & r_tag_o[RD_LAT-1])
            cpu_rdata <= mem_rdata;
      end
   end

`ifdef VGA_MEM_ARB_STATS_EN
   logic        r_bright_q;
   logic [15:0] r_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bright_q <= 1'b0;
         r_stall    <= '0;
      end else begin
         r_bright_q <= bright;
         if (bright & ~r_bright_q)
            r_stall <= '0;
         else if (disp_req & ~w_disp_gnt & (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
      end
   end

   assign disp_stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: scoreboard bench for vga_mem_arbiter (RD_LAT=1).
// Includes a write-first synchronous-read memory model.
module tb_vga_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        bright;
   logic        disp_req;
   logic [15:0] disp_addr;
   logic        disp_gnt;
   logic [15:0] disp_rdata;
   logic        disp_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic [15:0] cpu_rdata;
   logic        cpu_valid;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata = '0;
`ifdef VGA_MEM_ARB_STATS_EN
   logic [15:0] stall;
`endif

   typedef struct {
      logic        own;
      logic [15:0] d;
      int          due;
   } sb_t;

   sb_t         sbq[$];
   logic [15:0] mem [0:1023];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   vga_mem_arbiter #(
      .ADDR_W(16), .DATA_W(16), .RD_LAT(1), .CPU_MAX_WAIT(4)
   ) dut (
      .clk(clk), .reset(reset), .bright(bright),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_gnt(disp_gnt), .disp_rdata(disp_rdata),
      .disp_valid(disp_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
      .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef VGA_MEM_ARB_STATS_EN
      , .disp_stall_cnt(stall)
`endif
   );

   function automatic logic [15:0] f_init(input logic [15:0] a);
      return (a * 16'h0101) ^ 16'h5A00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] <= f_init(16'(i));
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we)
         mem[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : mem[mem_addr[9:0]];
   end

   // Scoreboard: push on read grant, pop on any valid.
   always @(negedge clk) begin
      if (!reset) begin
         sbq.delete();
      end else begin
         if (disp_valid | cpu_valid) begin
            chk("sb_one_valid", disp_valid & cpu_valid, 0);
            if (sbq.size() == 0) begin
               chk("sb_spurious", {disp_valid, cpu_valid}, 0);
            end else begin
               sb_t e;
               e = sbq.pop_front();
               chk("sb_owner", cpu_valid, e.own);
               chk("sb_data", cpu_valid ? cpu_rdata : disp_rdata, e.d);
               chk("sb_lat", cyc, e.due);
            end
         end
         if (sbq.size() != 0 && cyc > sbq[0].due)
            chk("sb_missing", cyc, sbq[0].due);
         if (disp_gnt | (cpu_gnt & ~cpu_we)) begin
            sb_t n;
            n.own = cpu_gnt;
            n.d   = mem[mem_addr[9:0]];
            n.due = cyc + 2;
            sbq.push_back(n);
         end
      end
   end

   initial begin
      reset     = 1'b0;
      bright    = 1'b0;
      disp_req  = 1'b1;
      disp_addr = 16'h0040;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 16'h0100;
      cpu_wdata = 16'h1234;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_disp_gnt", disp_gnt, 0);
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_valids", {disp_valid, cpu_valid}, 0);
      chk("rst_rdata", {disp_rdata, cpu_rdata}, 0);

      tick();
      reset   = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("first_gnt", disp_gnt, 1);
      chk("first_addr", mem_addr, 16'h0040);
      tick();
      disp_req = 1'b0;
      @(negedge clk);
      chk("first_early", disp_valid, 0);
      tick();
      @(negedge clk);
      chk("first_valid", disp_valid, 1);
      chk("first_data", disp_rdata, f_init(16'h0040));
      tick();

      bright    = 1'b1;
      disp_req  = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      disp_addr = 16'h0010;
      cpu_addr  = 16'h0020;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("prio_seq", {cpu_gnt, disp_gnt},
             (i % 5 == 4) ? 2'b10 : 2'b01);
         tick();
      end

      bright = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("blank_cpu", {cpu_gnt, disp_gnt}, 2'b10);
         tick();
      end
      bright = 1'b1;
      @(negedge clk);
      chk("blank_rise", {cpu_gnt, disp_gnt}, 2'b01);
      tick();
      disp_req = 1'b0;
      cpu_req  = 1'b0;
      bright   = 1'b0;
      repeat (3) tick();

      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 16'h0100;
      cpu_wdata = 16'hBEEF;
      @(negedge clk);
      chk("wr_gnt", cpu_gnt, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 16'h0100);
      tick();
      cpu_we = 1'b0;
      @(negedge clk);
      chk("rd_we", mem_we, 0);
      chk("rd_gnt", cpu_gnt, 1);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("wr_no_valid", cpu_valid, 0);
      chk("addr_hold", mem_addr, 16'h0100);
      chk("idle_we", mem_we, 0);
      tick();
      @(negedge clk);
      chk("raw_valid", cpu_valid, 1);
      chk("raw_data", cpu_rdata, 16'hBEEF);
      tick();

      disp_req  = 1'b1;
      disp_addr = 16'h0010;
      @(negedge clk);
      tick();
      disp_req = 1'b0;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h0020;
      @(negedge clk);
      tick();
      cpu_req   = 1'b0;
      disp_req  = 1'b1;
      disp_addr = 16'h0011;
      @(negedge clk);
      tick();
      disp_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("il_disp_clean", disp_rdata == f_init(16'h0020), 0);
         tick();
      end
      chk("il_disp_last", disp_rdata, f_init(16'h0011));
      chk("il_cpu_last", cpu_rdata, f_init(16'h0020));

      disp_req  = 1'b1;
      disp_addr = 16'h0040;
      @(negedge clk);
      chk("mf_gnt", disp_gnt, 1);
      tick();
      disp_req = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mf_no_valid", {disp_valid, cpu_valid}, 0);
         tick();
      end
      chk("mf_rdata_clr", {disp_rdata, cpu_rdata}, 0);
      chk("sb_drain", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
